lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- MEM-stage load/store initiator that drives the byte-addressed 64-bit data memory port: `adrs`, `writedata2In`, `memRead`, `memWrite` out; `rdOut` in.
- Converts RV64 sized accesses into full 8-byte memory transactions.
  - Loads: sign/zero extension.
  - Sub-doubleword stores: read-modify-write.
- Stalls the pipeline while a transaction is in flight.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; legal access requires addr+7 <= MEM_BYTES-1.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  MEM-stage access request; held stable with all request fields while stall=1.
- ld_en  in  1  load request.
- st_en  in  1  store request.
- funct3  in  3  RV64 size/sign code.
- addr  in  64  byte address (ALU result).
- st_data  in  64  store data, low bytes significant.
- ld_data  out  64  extended load result, valid when done=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse; no memory access is made.
- stall  out  1  pipeline hold.
- adrs  out  64  memory address.
- writedata2In  out  64  memory write data.
- memRead  out  1  memory read enable; memory returns rdOut combinationally.
- memWrite  out  1  memory write enable; memory writes 8 bytes adrs..adrs+7 at posedge.
- rdOut  in  64  memory read data.

Behaviour:
- States: IDLE, RMW_WR, DONE.
- Reset (sync, rst=1 at posedge): state=IDLE; ld_data=0, captured read buffer=0; done=err=0.
  - memRead=memWrite=0 combinationally in any cycle rst=1, so a reset mid-RMW never issues the write.
- funct3 codes:
  - 000 byte, 001 half, 010 word, 011 double: signed for loads, size for stores.
  - 100 bu, 101 hu, 110 wu: unsigned loads.
  - 111 illegal.
- adrs = addr in every non-IDLE cycle and in IDLE when req=1.
- Outputs are 0 when not driven.
- Error check in IDLE with req=1. Any of the following gives err=1 next cycle with state→DONE, no memRead/memWrite:
  - ld_en&st_en both set;
  - funct3=111;
  - funct3 in {100,101,110} with st_en;
  - addr > MEM_BYTES-8.
- req=1 with ld_en=st_en=0: treated as done in IDLE.
  - State→DONE.
  - No access.
- Load, IDLE:
  - memRead=1; rdOut registered at posedge.
  - Extraction: low 8/16/32/64 bits of rdOut, sign- or zero-extended to ld_data.
  - State→DONE.
  - Latency: done in cycle 1 after acceptance.
- Store double (011), IDLE: memWrite=1, writedata2In=st_data; state→DONE; done in cycle 1.
- Store byte/half/word, IDLE:
  - memRead=1; rdOut captured into buffer; state→RMW_WR.
  - RMW_WR: memWrite=1, writedata2In = buffer with low 1/2/4 bytes replaced by st_data low bytes; state→DONE.
  - done in cycle 2.
- DONE:
  - done=1 (or err=1); stall=0; state→IDLE.
  - req still high in DONE is not re-accepted.
- stall = req & (state!=DONE) & ~rst.
- ld_data holds its last value until the next load completes.
- Back-to-back requests: the next request is accepted in the IDLE cycle following DONE.
- Boundary address MEM_BYTES-8 is legal; MEM_BYTES-7 errors.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: in addition to the error checks, addr not naturally aligned raises err with no access.
  - half: addr[0]!=0
  - word: addr[1:0]!=0
  - double: addr[2:0]!=0
- Undefined: misaligned addresses are performed normally; the byte-addressed memory handles them natively.

Test Plan:
- Reset then idle: rst=1 two cycles → ld_data=0, done=err=stall=memRead=memWrite=0.
- sd then ld: sd addr=0x10, st_data=0xDEADBEEF_CAFEF00D → memWrite in cycle 0, done cycle 1. ld addr=0x10, funct3=011 → ld_data=0xDEADBEEF_CAFEF00D at done, stall high exactly 1 cycle.
- Signed/unsigned byte: memory byte 0x10=0x0D.
  - lb addr=0x11 (byte 0xF0) → 0xFFFFFFFF_FFFFFFF0.
  - lbu → 0x00000000_000000F0.
  - lh addr=0x10 → 0xFFFFFFFF_FFFFF00D.
- RMW store: sb addr=0x10, st_data=0xAA.
  - Cycle 0: memRead.
  - Cycle 1: memWrite with writedata2In=0xDEADBEEF_CAFEF0AA.
  - Cycle 2: done.
  - Subsequent ld → 0xDEADBEEF_CAFEF0AA.
- Errors: each of the following → err pulse cycle 1, no memRead/memWrite, memory unchanged.
  - ld addr=1017 (MEM_BYTES=1024);
  - funct3=111;
  - st_en with funct3=100;
  - ld_en=st_en=1.
- Reset mid-RMW: sw issued, rst=1 in RMW_WR cycle → memWrite stays 0, memory unchanged, state IDLE. With LSU_MISALIGN_TRAP_EN, lw addr=0x12 → err; without it → correct 4 bytes loaded.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator: turns RV64 sized accesses into 8-byte memory
// transactions (extension on loads, read-modify-write on sub-doubleword stores).
// Optional build macro: LSU_MISALIGN_TRAP_EN adds natural-alignment error checks.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       st_data,
  output logic [63:0]       ld_data,
  output logic              done,
  output logic              err,
  output logic              stall,
  output logic [ADDR_W-1:0] adrs,
  output logic [63:0]       writedata2In,
  output logic              memRead,
  output logic              memWrite,
  input  logic [63:0]       rdOut
);

  typedef enum logic [1:0] {IDLE, RMW_WR, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - 8);

  state_t      state, state_nxt;
  logic [63:0] rd_buf;
  logic        err_q, err_nxt;
  logic        ld_cap, buf_cap;
  logic        bad_req;

  function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] d);
    case (f3)
      3'b000:  load_extend = {{56{d[7]}}, d[7:0]};
      3'b001:  load_extend = {{48{d[15]}}, d[15:0]};
      3'b010:  load_extend = {{32{d[31]}}, d[31:0]};
      3'b100:  load_extend = {56'd0, d[7:0]};
      3'b101:  load_extend = {48'd0, d[15:0]};
      3'b110:  load_extend = {32'd0, d[31:0]};
      default: load_extend = d;
    endcase
  endfunction

  // Only the low 1/2/4 bytes of the old doubleword are replaced.
  function automatic logic [63:0] store_merge(input logic [1:0] sz, input logic [63:0] old,
                                              input logic [63:0] sd);
    case (sz)
      2'b00:   store_merge = {old[63:8], sd[7:0]};
      2'b01:   store_merge = {old[63:16], sd[15:0]};
      2'b10:   store_merge = {old[63:32], sd[31:0]};
      default: store_merge = sd;
    endcase
  endfunction

  always_comb begin
    bad_req = (ld_en && st_en) || (funct3 == 3'b111) || (st_en && funct3[2]) ||
              (addr > LAST_LEGAL);
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   bad_req = bad_req || addr[0];
      2'b10:   bad_req = bad_req || (addr[1:0] != 2'b00);
      2'b11:   bad_req = bad_req || (addr[2:0] != 3'b000);
      default: ;
    endcase
`endif
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_nxt    = state;
    err_nxt      = err_q;
    adrs         = '0;
    writedata2In = '0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    ld_cap       = 1'b0;
    buf_cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          adrs      = addr;
          state_nxt = DONE;
          err_nxt   = bad_req;
          if (!bad_req) begin
            if (ld_en) begin
              memRead = 1'b1;
              ld_cap  = 1'b1;
            end else if (st_en && funct3 == 3'b011) begin
              memWrite     = 1'b1;
              writedata2In = st_data;
            end else if (st_en) begin
              memRead   = 1'b1;
              buf_cap   = 1'b1;
              state_nxt = RMW_WR;
            end
          end
        end
      end
      RMW_WR: begin
        adrs         = addr;
        memWrite     = 1'b1;
        writedata2In = store_merge(funct3[1:0], rd_buf, st_data);
        state_nxt    = DONE;
      end
      DONE: begin
        adrs      = addr;
        done      = !err_q;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A reset landing in RMW_WR must never let the write reach memory.
    if (rst) begin
      memRead  = 1'b0;
      memWrite = 1'b0;
    end
  end

  assign stall = req && (state != DONE) && !rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    if (rst) begin
      state   <= IDLE;
      ld_data <= '0;
      rd_buf  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (ld_cap)  ld_data <= load_extend(funct3, rdOut);
      if (buf_cap) rd_buf  <= rdOut;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 1 KiB byte-addressed memory model.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, req, ld_en, st_en;
  logic [2:0]  funct3;
  logic [63:0] addr, st_data, ld_data, adrs, writedata2In, rdOut;
  logic        done, err, stall, memRead, memWrite;

  logic [7:0]  mem [0:1023];
  int          wr_total = 0;
  int          n_checks = 0;
  int          n_err = 0;

  // Per-access observations
  int          lat, n_rd, n_wr, n_stall, rd_cyc, wr_cyc;
  logic [63:0] wd, ld_val, adrs0;
  logic        got_err;

  lsu_mem_ctrl #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .req(req), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
    .addr(addr), .st_data(st_data), .ld_data(ld_data), .done(done), .err(err),
    .stall(stall), .adrs(adrs), .writedata2In(writedata2In), .memRead(memRead),
    .memWrite(memWrite), .rdOut(rdOut)
  );

  always #5 clk = ~clk;

  always_comb begin
    rdOut = '0;
    if (memRead && adrs <= 64'd1016)
      for (int i = 0; i < 8; i++) rdOut[8*i +: 8] = mem[adrs[9:0] + 10'(i)];
  end

  always @(posedge clk) begin
    if (memWrite && adrs <= 64'd1016) begin
      for (int i = 0; i < 8; i++) mem[adrs[9:0] + 10'(i)] = writedata2In[8*i +: 8];
      wr_total++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  // Issue one request in an IDLE cycle and follow it until done/err (bounded).
  task automatic access(input logic l, input logic s, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    req = 1'b1; ld_en = l; st_en = s; funct3 = f3; addr = a; st_data = d;
    #1;
    lat = -1; n_rd = 0; n_wr = 0; n_stall = 0; rd_cyc = -1; wr_cyc = -1;
    wd = '0; got_err = 1'b0; ld_val = '0; adrs0 = adrs;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      if (memRead) begin n_rd++; if (rd_cyc < 0) rd_cyc = c; end
      if (memWrite) begin n_wr++; wr_cyc = c; wd = writedata2In; end
      if (stall) n_stall++;
      if (done || err) begin
        lat = c; got_err = err; ld_val = ld_data;
        break;
      end
    end
    req = 1'b0; ld_en = 1'b0; st_en = 1'b0;
  endtask

  task automatic expect_err(input string tag, input logic [63:0] prev_ld);
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_err"}, 64'(got_err), 64'd1);
    check({tag, "_noacc"}, 64'(n_rd + n_wr), 64'd0);
    check({tag, "_ldhold"}, ld_val, prev_ld);
  endtask

  initial begin
    int wr_before;
    rst = 1'b1; req = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    funct3 = '0; addr = '0; st_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    // Reset: a request during reset must not stall or touch memory.
    @(posedge clk); #1;
    req = 1'b1; ld_en = 1'b1; funct3 = 3'b011; addr = 64'h10;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_memread", 64'(memRead), 64'd0);
    @(posedge clk); #1;
    req = 1'b0; ld_en = 1'b0; rst = 1'b0;
    #1;
    check("rst_ld_data", ld_data, 64'd0);
    check("rst_outs", {59'd0, done, err, stall, memRead, memWrite}, 64'd0);

    // sd then ld at 0x10
    access(1'b0, 1'b1, 3'b011, 64'h10, 64'hDEADBEEF_CAFEF00D);
    check("sd_lat", 64'(lat), 64'd1);
    check("sd_wr_cyc", 64'(wr_cyc), 64'd0);
    check("sd_wd", wd, 64'hDEADBEEF_CAFEF00D);
    check("sd_rd", 64'(n_rd), 64'd0);
    check("sd_adrs", adrs0, 64'h10);
    access(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    check("ld_val", ld_val, 64'hDEADBEEF_CAFEF00D);
    check("ld_lat", 64'(lat), 64'd1);
    check("ld_stall", 64'(n_stall), 64'd1);
    check("ld_rd_once", 64'(n_rd), 64'd1);

    // Sign/zero extension
    access(1'b1, 1'b0, 3'b000, 64'h11, 64'h0);
    check("lb", ld_val, 64'hFFFFFFFF_FFFFFFF0);
    access(1'b1, 1'b0, 3'b100, 64'h11, 64'h0);
    check("lbu", ld_val, 64'h00000000_000000F0);
    access(1'b1, 1'b0, 3'b001, 64'h10, 64'h0);
    check("lh", ld_val, 64'hFFFFFFFF_FFFFF00D);
    access(1'b1, 1'b0, 3'b101, 64'h10, 64'h0);
    check("lhu", ld_val, 64'h00000000_0000F00D);
    access(1'b1, 1'b0, 3'b010, 64'h10, 64'h0);
    check("lw", ld_val, 64'hFFFFFFFF_CAFEF00D);
    access(1'b1, 1'b0, 3'b110, 64'h10, 64'h0);
    check("lwu", ld_val, 64'h00000000_CAFEF00D);

    // RMW byte store
    access(1'b0, 1'b1, 3'b000, 64'h10, 64'hAA);
    check("sb_rd_cyc", 64'(rd_cyc), 64'd0);
    check("sb_wr_cyc", 64'(wr_cyc), 64'd1);
    check("sb_wd", wd, 64'hDEADBEEF_CAFEF0AA);
    check("sb_lat", 64'(lat), 64'd2);
    check("sb_stall", 64'(n_stall), 64'd2);
    access(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    check("sb_readback", ld_val, 64'hDEADBEEF_CAFEF0AA);

    // RMW half store at an offset crossing into zeroed memory
    access(1'b0, 1'b1, 3'b001, 64'h14, 64'hFFFF_FFFF_FFFF_1234);
    check("sh_wd", wd, 64'h00000000_DEAD1234);
    access(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    check("sh_readback", ld_val, 64'hDEAD1234_CAFEF0AA);

    // Boundary: MEM_BYTES-8 is legal
    access(1'b0, 1'b1, 3'b011, 64'd1016, 64'h01234567_89ABCDEF);
    check("edge_sd_wr", 64'(n_wr), 64'd1);
    access(1'b1, 1'b0, 3'b011, 64'd1016, 64'h0);
    check("edge_ld", ld_val, 64'h01234567_89ABCDEF);
    check("edge_ld_err", 64'(got_err), 64'd0);

    // Errors: no access, ld_data held, memory unchanged
    wr_before = wr_total;
    access(1'b1, 1'b0, 3'b011, 64'd1017, 64'h0);
    expect_err("e_addr", 64'h01234567_89ABCDEF);
    access(1'b1, 1'b0, 3'b111, 64'h10, 64'h0);
    expect_err("e_f3_111", 64'h01234567_89ABCDEF);
    access(1'b0, 1'b1, 3'b100, 64'h10, 64'h5555);
    expect_err("e_st_unsigned", 64'h01234567_89ABCDEF);
    access(1'b1, 1'b1, 3'b011, 64'h10, 64'h0);
    expect_err("e_ld_st", 64'h01234567_89ABCDEF);
    check("e_no_writes", 64'(wr_total - wr_before), 64'd0);
    access(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    check("e_mem_kept", ld_val, 64'hDEAD1234_CAFEF0AA);

    // Request with neither ld_en nor st_en completes without an access
    access(1'b0, 1'b0, 3'b011, 64'h10, 64'h0);
    check("noop_lat", 64'(lat), 64'd1);
    check("noop_done", {62'd0, got_err, 1'b0} | 64'(n_rd + n_wr), 64'd0);

    // Reset landing in RMW_WR
    wr_before = wr_total;
    @(posedge clk); #1;
    req = 1'b1; st_en = 1'b1; funct3 = 3'b010; addr = 64'h20; st_data = 64'h55667788;
    #1;
    check("rmw_rst_rd", 64'(memRead), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rmw_rst_wr", 64'(memWrite), 64'd0);
    check("rmw_rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; st_en = 1'b0;
    #1;
    check("rmw_rst_idle", {60'd0, done, err, memRead, memWrite}, 64'd0);
    check("rmw_rst_nowr", 64'(wr_total - wr_before), 64'd0);
    access(1'b1, 1'b0, 3'b011, 64'h20, 64'h0);
    check("rmw_rst_mem", ld_val, 64'h0);

    // Misaligned word load
    access(1'b1, 1'b0, 3'b010, 64'h12, 64'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", 64'(got_err), 64'd1);
    check("lw_mis_noacc", 64'(n_rd), 64'd0);
`else
    check("lw_mis_err", 64'(got_err), 64'd0);
    check("lw_mis_val", ld_val, 64'h00000000_1234CAFE);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
